calc_seg_display: RTL
=====================

Name: calc_seg_display

Overview:
- Downstream stage of calc_top: consumes the 16-bit calculator result and drives the board's 8-digit multiplexed seven-segment display.
- Converts the unsigned binary result to 5 BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Scans the digits with a refresh counter and blanks leading zeros.
- Sits beside calc_top under the board-level wrapper on the same 100 MHz clock.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit slot is held active (1 ms at 100 MHz); the bench overrides it with a small value. Counter width is $clog2(REFRESH_DIV).

Ports:
- CLK100MHZ  input  1  system clock; all logic on the rising edge.
- CPU_RESETN  input  1  reset, asynchronous assert, active-low.
- value  input  16  unsigned result from calc_top out.
- bcd  output  20  last completed conversion, 5 nibbles, nibble 0 = ones.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd updates.
- AN  output  8  digit anodes, active-low, one-cold.
- SEG  output  7  {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point, active-low, held 1 (off).

Behaviour:
- Reset values (CPU_RESETN low, immediate): bcd=0, busy=0, done=0, AN=8'hFF, SEG=7'h7F, DP=1, last_value=0, state=IDLE, refresh counter=0, digit index=0.
- Reset mid-conversion aborts the conversion; the bcd register is cleared and nothing partial is ever exposed.
- After reset release, if value != last_value, that value converts through the normal IDLE rule.
- FSM states: IDLE, CONV.
- IDLE: at a clock edge where value != last_value, capture last_value<=value, load shift register {20'b0,value}, iteration count=0, busy<=1, go to CONV. Otherwise stay in IDLE.
- CONV: each edge, add 3 to every BCD nibble >=5, then shift the 36-bit register left by 1 and increment the count.
- On the 16th shift edge: bcd<=upper 20 bits, done<=1 for exactly one cycle, busy<=0, go to IDLE.
- Latency: start edge E0; bcd and done are valid after edge E16. busy is high for exactly 16 cycles.
- value is ignored while busy. A change during CONV is picked up in IDLE the cycle after completion because value != last_value, so the final converted value always equals the final input.
- A change back to the same value mid-conversion causes no second conversion.
- Range: 0..65535 always fits 5 BCD digits; no overflow case exists.
- Scan: the refresh counter runs 0..REFRESH_DIV-1. On wrap, the digit index increments 0..7 and wraps 7->0.
- Slot d: AN[d]=0 and all other AN bits 1, unless the slot is blanked.
- Blanking: a slot is blanked (AN=8'hFF, SEG=7'h7F) if d>=5, or if d>0 and bcd nibbles d..4 are all zero. Digit 0 is never blanked, so 0 shows as "0".
- SEG is driven from bcd (last completed value only), never from in-flight shift data. Decode is combinational from registered index/bcd; AN and SEG are registered.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Nibbles >9 cannot occur; decode them as blank.

Test Plan:
- Reset with value=0, REFRESH_DIV=4 -> no conversion, busy stays 0. Slot 0 shows AN=8'hFE, SEG=1000000; slots 1-7 show AN=8'hFF.
- value 0->255 -> busy high for 16 cycles, single done pulse, bcd=20'h00255. Slots 0,1,2 show 5,5,2; slots 3-7 are blanked.
- value=65535 -> bcd=20'h65535; slots 0-4 lit with 5,3,5,5,6; slots 5-7 blanked.
- value=100, then 42 applied at cycle 5 of the conversion -> done pulses with bcd=20'h00100. The next cycle starts a new conversion; the second done gives bcd=20'h00042. Exactly two done pulses.
- CPU_RESETN pulled low at cycle 8 of converting 9999 -> bcd=0, busy=0, AN=8'hFF immediately. After release with value=9999 held, conversion reruns and gives bcd=20'h09999.
- REFRESH_DIV=4, value=1024 -> digit index advances every 4 cycles and wraps 7->0 after 32 cycles. The AN sequence is FE,FD,FB,F7 then FF x4, and slot 2 shows 0 (interior zero not blanked).

Source files
------------

// File: rtl/calc_seg_display.sv
// Binary-to-BCD converter (sequential double-dabble) feeding an 8-digit
// multiplexed seven-segment display with leading-zero blanking.
module calc_seg_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [15:0] value,
  output logic [19:0] bcd,
  output logic        busy,
  output logic        done,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] last_q, last_d;
  logic [35:0] shift_q, shift_d;
  logic [4:0]  iter_q, iter_d;
  logic [19:0] bcd_q, bcd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [35:0] adj_s;
  logic [35:0] next_shift_s;

  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q;
  logic [31:0]      bcd_ext_s;
  logic [3:0]       nib_s;
  logic             upper_zero_s;
  logic             blank_s;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Conversion state, shift register and result registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
      last_q  <= 16'd0;
      shift_q <= 36'd0;
      iter_q  <= 5'd0;
      bcd_q   <= 20'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: start on a new input value, then 16 adjust-and-shift steps.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    shift_d      = shift_q;
    iter_d       = iter_q;
    bcd_d        = bcd_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    adj_s        = {add3(shift_q[35:16]), shift_q[15:0]};
    next_shift_s = {adj_s[34:0], 1'b0};
    case (state_q)
      IDLE: begin
        if (value != last_q) begin
          last_d  = value;
          shift_d = {20'd0, value};
          iter_d  = 5'd0;
          busy_d  = 1'b1;
          state_d = CONV;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      CONV: begin
        shift_d = next_shift_s;
        iter_d  = iter_q + 5'd1;
        if (iter_q == 5'd15) begin
          bcd_d   = next_shift_s[35:16];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Refresh counter, digit index and registered display drive.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      refresh_q <= '0;
      idx_q     <= 3'd0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= 1'b1;
    end
  end

  // Scan timing and digit decode; only the completed bcd value is displayed.
  always_comb begin
    refresh_d    = refresh_q;
    idx_d        = idx_q;
    bcd_ext_s    = {12'd0, bcd_q};
    nib_s        = bcd_ext_s[{idx_q, 2'b00} +: 4];
    upper_zero_s = ((bcd_ext_s >> {idx_q, 2'b00}) == 32'd0);
    blank_s      = 1'b0;
    an_d         = 8'hFF;
    seg_d        = 7'h7F;

    if (refresh_q == CNT_MAX) begin
      refresh_d = '0;
      idx_d     = idx_q + 3'd1;
    end else begin
      refresh_d = refresh_q + {{(CNT_W-1){1'b0}}, 1'b1};
      idx_d     = idx_q;
    end

    if (idx_q >= 3'd5) begin
      blank_s = 1'b1;
    end else if ((idx_q != 3'd0) && upper_zero_s) begin
      blank_s = 1'b1;
    end else begin
      blank_s = 1'b0;
    end

    case (nib_s)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'h7F;
    endcase

    if (blank_s || (nib_s > 4'd9)) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
    end else begin
      an_d  = ~(8'd1 << idx_q);
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign done = done_q;
  assign AN   = an_q;
  assign SEG  = seg_q;
  assign DP   = dp_q;

endmodule
